mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Responder-side data-memory controller that produces the data-ready signal consumed by the pipeline hazard/stall logic.
- Accepts load/store requests from the MA stage and runs a req/ack handshake to data memory.
- Holds data-ready low while an access is outstanding, which stalls IF/ID.
- Returns load data, aligned and registered, to the MA stage.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature

Ports:
clk  input  1  system clock; rising edge
rst_n  input  1  asynchronous active-low reset
i_req_rd  input  1  MA-stage load request; held until a ready cycle
i_req_wr  input  1  MA-stage store request; held until a ready cycle
i_addr  input  ADDR_WIDTH  byte address
i_wdata  input  DATA_WIDTH  store data
i_wstrb  input  DATA_WIDTH/8  byte enables for a store
o_rdata  output  DATA_WIDTH  load data, valid while o_data_ready=1 in DONE
o_data_ready  output  1  memory ready toward the hazard unit; 0 stalls the pipeline
o_err  output  1  one-cycle error pulse
o_mem_req  output  1  memory request, registered
o_mem_we  output  1  1=write, 0=read
o_mem_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] = 0
o_mem_wdata  output  DATA_WIDTH  write data
o_mem_wstrb  output  DATA_WIDTH/8  write strobes
i_mem_ack  input  1  memory completion; one-cycle pulse
i_mem_rdata  input  DATA_WIDTH  read data, valid with i_mem_ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr/wdata/wstrb=0, o_rdata=0, o_err=0. o_data_ready=1 once in IDLE with no request.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - o_data_ready = !(i_req_rd|i_req_wr), combinational, so the stall asserts in the same cycle the request appears.
  - On a request: capture address (bits [1:0] forced 0), wdata, wstrb and we=i_req_wr; go to REQ.
- REQ:
  - o_mem_req=1, o_data_ready=0, memory outputs held stable.
  - On i_mem_ack: capture i_mem_rdata into o_rdata (reads only; writes leave o_rdata unchanged); go to DONE, drop o_mem_req.
- DONE:
  - o_data_ready=1 for exactly one cycle; requester advances on this edge.
  - Any request present during DONE is the completed one and is ignored.
  - Next state is IDLE.
- Latency: request seen at cycle 0, o_mem_req at cycle 1. With ack at cycle 1, DONE is at cycle 2. Each extra ack-wait cycle adds one.
- Simultaneous i_req_rd & i_req_wr in IDLE: treated as a store (write priority); o_err pulses in the capture cycle.
- i_mem_ack in IDLE or DONE: ignored; no state change, no error.
- Reset mid-transaction: o_mem_req drops immediately (async) and the transaction is lost; the memory model must tolerate an abandoned request.
- Width rules: DATA_WIDTH a multiple of 8; o_mem_wstrb=0 on reads.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-min counter, cleared on entering REQ, increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: abort to DONE, drop o_mem_req, set o_rdata=MEM_ABORT_DATA (32'hDEAD_BEEF), pulse o_err.
  - An ack in the same cycle as expiry wins; normal completion, no error.
- Without the macro: no counter logic; REQ waits indefinitely.

Decomposition:
- Shared package riscv_definitions:
  - typedef enum logic [1:0] mem_state_t {MEM_IDLE, MEM_REQ, MEM_DONE}
  - localparam MEM_ABORT_DATA
- Sub-module mem_watchdog (counter, clear/enable inputs, expired output), instantiated only under MEM_ACCESS_TIMEOUT_EN.

Test Plan:
- Load, zero-wait: i_req_rd=1, i_addr=0x1003, ack one cycle after o_mem_req with rdata=0xCAFEF00D.
  -> o_mem_addr=0x1000 and o_data_ready=0 in cycles 0-1; cycle 2 o_data_ready=1, o_rdata=0xCAFEF00D.
- Store with 3 wait cycles: i_req_wr=1, i_wdata=0x11223344, wstrb=4'b0011.
  -> o_mem_we=1, strobes 0011 held 4 cycles; DONE on cycle 5; o_rdata unchanged.
- Rd+wr collision: both high at addr 0x20.
  -> store issued, o_err=1 for one cycle, completes normally.
- Spurious ack in IDLE, then async reset asserted during REQ.
  -> no state change on ack; o_mem_req=0 immediately on reset; o_data_ready=1 after release.
- Back-to-back loads: second request held high through DONE.
  -> second access begins only in the following IDLE cycle; exactly two o_mem_req assertions.
- MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack.
  -> abort after 8 REQ cycles; o_rdata=0xDEADBEEF, o_err pulse, o_data_ready=1 one cycle.

Source files
------------

// File: rtl/riscv_definitions.sv
// riscv_definitions: memory-access FSM states and the data returned on an aborted access
package riscv_definitions;
   typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t;
   localparam logic [31:0] MEM_ABORT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MA-stage request side and data-memory side of the access controller
interface mem_access_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    i_req_rd;
   logic                    i_req_wr;
   logic [ADDR_WIDTH-1:0]   i_addr;
   logic [DATA_WIDTH-1:0]   i_wdata;
   logic [DATA_WIDTH/8-1:0] i_wstrb;
   logic [DATA_WIDTH-1:0]   o_rdata;
   logic                    o_data_ready;
   logic                    o_err;
   logic                    o_mem_req;
   logic                    o_mem_we;
   logic [ADDR_WIDTH-1:0]   o_mem_addr;
   logic [DATA_WIDTH-1:0]   o_mem_wdata;
   logic [DATA_WIDTH/8-1:0] o_mem_wstrb;
   logic                    i_mem_ack;
   logic [DATA_WIDTH-1:0]   i_mem_rdata;
   modport slave (
      input  i_req_rd, i_req_wr, i_addr, i_wdata, i_wstrb, i_mem_ack, i_mem_rdata,
      output o_rdata, o_data_ready, o_err, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
   );
   modport master (
      output i_req_rd, i_req_wr, i_addr, i_wdata, i_wstrb, i_mem_ack, i_mem_rdata,
      input  o_rdata, o_data_ready, o_err, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
   );
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts stalled request cycles; expired flags the last allowed cycle
module mem_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = ($clog2(LIMIT) > 8) ? $clog2(LIMIT) : 8;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + CW'(1);
   end
   assign expired = en && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: req/ack data-memory controller driving the pipeline data-ready stall.
// Define MEM_ACCESS_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT_CYCLES.
module mem_access_ctrl
   import riscv_definitions::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic clk,
   input logic rst_n,
   mem_access_ctrl_if.slave bus
);
   mem_state_t state_q, state_d;
   logic req_any, in_req, ack_ok, abort;
   assign req_any = bus.i_req_rd | bus.i_req_wr;
   assign in_req  = (state_q == MEM_REQ);
   assign ack_ok  = in_req && bus.i_mem_ack;
`ifdef MEM_ACCESS_TIMEOUT_EN
   logic wd_expired;
   mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_req),
      .en      (in_req && !bus.i_mem_ack),
      .expired (wd_expired)
   );
   assign abort = wd_expired;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign abort = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      if (state_q == MEM_IDLE && req_any) state_d = MEM_REQ;
      if (ack_ok || abort) state_d = MEM_DONE;
      if (state_q == MEM_DONE) state_d = MEM_IDLE;
   end
   // Stall must assert in the very cycle a request shows up, hence combinational in IDLE
   assign bus.o_data_ready = (state_q == MEM_IDLE) ? !req_any : (state_q == MEM_DONE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= MEM_IDLE;
         bus.o_mem_req   <= 1'b0;
         bus.o_mem_we    <= 1'b0;
         bus.o_mem_addr  <= '0;
         bus.o_mem_wdata <= '0;
         bus.o_mem_wstrb <= '0;
         bus.o_rdata     <= '0;
         bus.o_err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus.o_err <= 1'b0;
         if (state_q == MEM_IDLE && req_any) begin
            bus.o_mem_req   <= 1'b1;
            bus.o_mem_we    <= bus.i_req_wr;
            bus.o_mem_addr  <= {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
            bus.o_mem_wdata <= bus.i_wdata;
            bus.o_mem_wstrb <= bus.i_req_wr ? bus.i_wstrb : '0;
            bus.o_err       <= bus.i_req_rd & bus.i_req_wr;
         end
         if (ack_ok || abort) bus.o_mem_req <= 1'b0;
         if (ack_ok && !bus.o_mem_we) bus.o_rdata <= bus.i_mem_rdata;
         if (abort) begin
            bus.o_rdata <= DATA_WIDTH'(MEM_ABORT_DATA);
            bus.o_err   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven transactions with a read-data scoreboard plus corner sequences
module tb_mem_access_ctrl;
   logic clk;
   logic rst_n;
   int n_checks = 0;
   int n_fail = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;
   logic [31:0] model_rdata = 32'h0;
   logic [31:0] sb[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waits;
      logic [31:0] mem_rdata;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [3:0]  exp_wstrb;
      logic        exp_err;
   } txn_t;
   txn_t vec[6];

   mem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus.o_mem_req && !req_prev) req_rises++;
      req_prev = bus.o_mem_req;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input txn_t t);
      logic [31:0] exp;
      bus.i_req_rd = t.rd;
      bus.i_req_wr = t.wr;
      bus.i_addr   = t.addr;
      bus.i_wdata  = t.wdata;
      bus.i_wstrb  = t.wstrb;
      exp = t.wr ? model_rdata : t.mem_rdata;
      model_rdata = exp;
      sb.push_back(exp);
      #1 chk("stall_c0", 32'(bus.o_data_ready), 0);
      step();
      chk("req_c1", 32'(bus.o_mem_req), 1);
      chk("addr_c1", bus.o_mem_addr, t.exp_addr);
      chk("we_c1", 32'(bus.o_mem_we), 32'(t.exp_we));
      chk("wstrb_c1", 32'(bus.o_mem_wstrb), 32'(t.exp_wstrb));
      chk("wdata_c1", bus.o_mem_wdata, t.wdata);
      chk("err_c1", 32'(bus.o_err), 32'(t.exp_err));
      chk("stall_c1", 32'(bus.o_data_ready), 0);
      repeat (t.waits) begin
         step();
         chk("req_held", 32'(bus.o_mem_req), 1);
         chk("addr_held", bus.o_mem_addr, t.exp_addr);
         chk("wstrb_held", 32'(bus.o_mem_wstrb), 32'(t.exp_wstrb));
         chk("stall_wait", 32'(bus.o_data_ready), 0);
         chk("err_wait", 32'(bus.o_err), 0);
      end
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = t.mem_rdata;
      step();
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = 32'h5A5A_5A5A;
      chk("done_ready", 32'(bus.o_data_ready), 1);
      chk("done_req", 32'(bus.o_mem_req), 0);
      chk("done_rdata", bus.o_rdata, sb.pop_front());
      chk("done_err", 32'(bus.o_err), 0);
      bus.i_req_rd = 1'b0;
      bus.i_req_wr = 1'b0;
      step();
      chk("idle_ready", 32'(bus.o_data_ready), 1);
      chk("idle_req", 32'(bus.o_mem_req), 0);
   endtask

   initial begin
      int rises0;
      vec[0] = '{1, 0, 32'h0000_1003, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 32'h0000_1000, 0, 4'h0, 0};
      vec[1] = '{0, 1, 32'h0000_2002, 32'h1122_3344, 4'b0011, 3, 32'hBBBB_BBBB, 32'h0000_2000, 1, 4'b0011, 0};
      vec[2] = '{1, 1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 1, 32'hCCCC_CCCC, 32'h0000_0020, 1, 4'hF, 1};
      vec[3] = '{1, 0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h1234_5678, 32'h0000_0044, 0, 4'h0, 0};
      vec[4] = '{0, 1, 32'hFFFF_FFFF, 32'h0BAD_CAFE, 4'b1100, 0, 32'hDDDD_DDDD, 32'hFFFF_FFFC, 1, 4'b1100, 0};
      vec[5] = '{1, 0, 32'h0000_0007, 32'hFFFF_FFFF, 4'b1010, 0, 32'h0BAD_F00D, 32'h0000_0004, 0, 4'h0, 0};
      rst_n = 1'b0;
      bus.i_req_rd = 1'b0;
      bus.i_req_wr = 1'b0;
      bus.i_addr = '0;
      bus.i_wdata = '0;
      bus.i_wstrb = '0;
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rdata = '0;
      #2;
      chk("rst_req", 32'(bus.o_mem_req), 0);
      chk("rst_ready", 32'(bus.o_data_ready), 1);
      chk("rst_rdata", bus.o_rdata, 0);
      chk("rst_err", 32'(bus.o_err), 0);
      chk("rst_addr", bus.o_mem_addr, 0);
      chk("rst_we", 32'(bus.o_mem_we), 0);
      #10 rst_n = 1'b1;
      step();
      for (int i = 0; i < 6; i++) run_txn(vec[i]);

      // spurious ack while idle
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'hFFFF_0000;
      #1 chk("spur_ready", 32'(bus.o_data_ready), 1);
      step();
      bus.i_mem_ack = 1'b0;
      chk("spur_req", 32'(bus.o_mem_req), 0);
      chk("spur_rdata", bus.o_rdata, model_rdata);
      chk("spur_err", 32'(bus.o_err), 0);
      chk("spur_ready2", 32'(bus.o_data_ready), 1);

      // async reset in the middle of a request
      bus.i_req_rd = 1'b1;
      bus.i_addr = 32'h0000_0500;
      step();
      chk("arst_pre_req", 32'(bus.o_mem_req), 1);
      #1 rst_n = 1'b0;
      #1 chk("arst_req", 32'(bus.o_mem_req), 0);
      chk("arst_rdata", bus.o_rdata, 0);
      bus.i_req_rd = 1'b0;
      model_rdata = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("arst_ready", 32'(bus.o_data_ready), 1);
      chk("arst_req_after", 32'(bus.o_mem_req), 0);

      // back-to-back loads, second request already present during DONE
      rises0 = req_rises;
      bus.i_req_rd = 1'b1;
      bus.i_addr = 32'h0000_0100;
      step();
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'h1111_1111;
      step();
      bus.i_mem_ack = 1'b0;
      bus.i_addr = 32'h0000_0204;
      chk("b2b_done1_rdata", bus.o_rdata, 32'h1111_1111);
      chk("b2b_done1_ready", 32'(bus.o_data_ready), 1);
      step();
      chk("b2b_idle_req", 32'(bus.o_mem_req), 0);
      chk("b2b_idle_stall", 32'(bus.o_data_ready), 0);
      step();
      chk("b2b_req2", 32'(bus.o_mem_req), 1);
      chk("b2b_addr2", bus.o_mem_addr, 32'h0000_0204);
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'h2222_2222;
      step();
      bus.i_mem_ack = 1'b0;
      chk("b2b_done2_rdata", bus.o_rdata, 32'h2222_2222);
      chk("b2b_done2_ready", 32'(bus.o_data_ready), 1);
      bus.i_req_rd = 1'b0;
      step();
      step();
      chk("b2b_rises", 32'(req_rises - rises0), 2);
      model_rdata = 32'h2222_2222;

`ifdef MEM_ACCESS_TIMEOUT_EN
      // no ack: abort after eight REQ cycles
      bus.i_req_rd = 1'b1;
      bus.i_addr = 32'h0000_0300;
      step();
      repeat (7) step();
      chk("to_req_c8", 32'(bus.o_mem_req), 1);
      chk("to_stall_c8", 32'(bus.o_data_ready), 0);
      step();
      chk("to_ready", 32'(bus.o_data_ready), 1);
      chk("to_req", 32'(bus.o_mem_req), 0);
      chk("to_rdata", bus.o_rdata, 32'hDEAD_BEEF);
      chk("to_err", 32'(bus.o_err), 1);
      bus.i_req_rd = 1'b0;
      step();
      chk("to_err_clr", 32'(bus.o_err), 0);
      chk("to_idle_ready", 32'(bus.o_data_ready), 1);
      // ack in the expiry cycle wins
      bus.i_req_rd = 1'b1;
      step();
      repeat (7) step();
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'h600D_D00D;
      step();
      bus.i_mem_ack = 1'b0;
      chk("toack_rdata", bus.o_rdata, 32'h600D_D00D);
      chk("toack_err", 32'(bus.o_err), 0);
      chk("toack_ready", 32'(bus.o_data_ready), 1);
      bus.i_req_rd = 1'b0;
      step();
`else
      // without the watchdog a request waits indefinitely
      bus.i_req_rd = 1'b1;
      bus.i_addr = 32'h0000_0300;
      step();
      repeat (20) step();
      chk("long_req", 32'(bus.o_mem_req), 1);
      chk("long_stall", 32'(bus.o_data_ready), 0);
      chk("long_err", 32'(bus.o_err), 0);
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'h600D_D00D;
      step();
      bus.i_mem_ack = 1'b0;
      chk("long_rdata", bus.o_rdata, 32'h600D_D00D);
      chk("long_ready", 32'(bus.o_data_ready), 1);
      bus.i_req_rd = 1'b0;
      step();
`endif
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
